qpsk_sym_scheduler: RTL and testbench

Output scheduler that sits between the Costas/bit-sync datapath and the AXI-stream source side of the QPSK NoC block. It selects which samples leave the block: all samples, one sample per symbol strobe, or packed hard-decision bits. It frames them into fixed-length packets with `tlast` and decouples the free-running sample rate from downstream backpressure through a small FIFO. Overflow events are counted for host readback.

---
 rtl/qpsk_pkg.sv | 24 ++
 rtl/qpsk_sched_fifo.sv | 42 ++++
 rtl/qpsk_sym_scheduler.sv | 164 ++++++++++++++++
 tb/tb_qpsk_sym_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// Shared constants, FSM state type and bit-packer helper for the QPSK output scheduler.
package qpsk_pkg;

    localparam logic [1:0] MODE_ALL  = 2'd0;
    localparam logic [1:0] MODE_SYM  = 2'd1;
    localparam logic [1:0] MODE_BITS = 2'd2;

    localparam int unsigned SR_QPSK_DISP_MODE = 130;
    localparam int unsigned SR_QPSK_SPP       = 131;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_e;

    // Left-align a partial packed word holding n dibits; LSBs are zero-filled.
    function automatic logic [31:0] pack_align(input logic [31:0] pack, input logic [3:0] n);
        logic [5:0] sh;
        sh = 6'd32 - {1'b0, n, 1'b0};
        return pack << sh;
    endfunction

endpackage

// File: rtl/qpsk_sched_fifo.sv
// Synchronous FIFO for {tlast, data} words; reads back zero while empty.
module qpsk_sched_fifo #(
    parameter int unsigned AW = 4,
    parameter int unsigned W  = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem [0:(1<<AW)-1];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop && !empty) rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    end

endmodule

// File: rtl/qpsk_sym_scheduler.sv
// Selects, packs and frames QPSK samples into fixed-length AXI-stream packets behind a FIFO.
module qpsk_sym_scheduler
    import qpsk_pkg::*;
#(
    parameter int unsigned SPP_W   = 12,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic             ce_clk,
    input  logic             ce_rst_n,
    input  logic             cfg_enable,
    input  logic [1:0]       cfg_mode,
    input  logic [SPP_W-1:0] cfg_spp,
    input  logic [31:0]      i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    input  logic             sym_stb,
    output logic [31:0]      o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [15:0]      ovf_cnt,
    output logic [15:0]      pkt_cnt,
    output logic             busy
);

    localparam logic [SPP_W-1:0] CntOne = {{(SPP_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             en_q;
    logic             en_rise;
    logic [1:0]       mode_q;
    logic [SPP_W-1:0] spp_last_q;
    logic [SPP_W-1:0] wcnt_q, wcnt_d;
    logic [31:0]      pack_q, pack_d;
    logic [3:0]       nsym_q, nsym_d;
    logic [15:0]      ovf_q, ovf_d;
    logic [15:0]      pkt_q;
    logic             cand;
    logic [31:0]      cand_data;
    logic             is_last;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    assign en_rise = cfg_enable && !en_q;

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state_q    <= StIdle;
            en_q       <= 1'b0;
            mode_q     <= MODE_ALL;
            spp_last_q <= '0;
            wcnt_q     <= '0;
            pack_q     <= '0;
            nsym_q     <= '0;
            ovf_q      <= '0;
            pkt_q      <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= cfg_enable;
            wcnt_q  <= wcnt_d;
            pack_q  <= pack_d;
            nsym_q  <= nsym_d;
            ovf_q   <= ovf_d;
            if (pop && o_tlast) pkt_q <= pkt_q + 16'd1;
            if (state_q == StIdle && en_rise) begin
                mode_q     <= (cfg_mode == 2'd3) ? MODE_SYM : cfg_mode;
                spp_last_q <= (cfg_spp == '0) ? '0 : cfg_spp - CntOne;
            end
        end
    end

    // Candidate generation, drop accounting and word framing.
    always_comb begin
        cand      = 1'b0;
        cand_data = i_tdata;
        push      = 1'b0;
        wcnt_d    = wcnt_q;
        pack_d    = pack_q;
        nsym_d    = nsym_q;
        ovf_d     = ovf_q;
        is_last   = (wcnt_q == spp_last_q);
        case (state_q)
            StIdle: begin
                if (en_rise) begin
                    wcnt_d = '0;
                    pack_d = '0;
                    nsym_d = '0;
                    ovf_d  = '0;
                end
            end
            StRun: begin
                if (i_tvalid) begin
                    case (mode_q)
                        MODE_ALL: cand = 1'b1;
                        MODE_BITS: begin
                            if (sym_stb) begin
                                pack_d    = {pack_q[29:0], i_tdata[31], i_tdata[15]};
                                nsym_d    = nsym_q + 4'd1;
                                cand      = (nsym_q == 4'd15);
                                cand_data = pack_d;
                            end
                        end
                        default: cand = sym_stb;
                    endcase
                end
                if (cand) begin
                    if (!fifo_full) push = 1'b1;
                    else if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
                end
            end
            StFlush: begin
                // Partial packed word goes first; afterwards pack_q is zero so padding is zero.
                cand_data = pack_align(pack_q, nsym_q);
                if (!fifo_full) begin
                    push   = 1'b1;
                    pack_d = '0;
                    nsym_d = '0;
                end
            end
            default: ;
        endcase
        if (push) wcnt_d = is_last ? '0 : wcnt_q + CntOne;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en_rise) state_d = StRun;
            StRun: begin
                if (!cfg_enable) begin
                    state_d = (wcnt_d == '0 && nsym_d == 4'd0) ? StIdle : StFlush;
                end
            end
            StFlush: if (push && is_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q != StIdle);
        i_tready = 1'b1;
        o_tvalid = !fifo_empty;
        pop      = o_tvalid && o_tready;
        ovf_cnt  = ovf_q;
        pkt_cnt  = pkt_q;
    end

    qpsk_sched_fifo #(
        .AW (FIFO_AW),
        .W  (33)
    ) u_fifo (
        .clk       (ce_clk),
        .rst_n     (ce_rst_n),
        .push      (push),
        .push_data ({is_last, cand_data}),
        .pop       (pop),
        .pop_data  ({o_tlast, o_tdata}),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_qpsk_sym_scheduler.sv
// Directed scoreboard bench for qpsk_sym_scheduler covering all modes, overflow, flush and reset.
module tb_qpsk_sym_scheduler;
    import qpsk_pkg::*;

    localparam int unsigned SPP_W   = 12;
    localparam int unsigned FIFO_AW = 4;

    logic             ce_clk     = 1'b0;
    logic             ce_rst_n   = 1'b0;
    logic             cfg_enable = 1'b0;
    logic [1:0]       cfg_mode   = 2'd0;
    logic [SPP_W-1:0] cfg_spp    = '0;
    logic [31:0]      i_tdata    = '0;
    logic             i_tvalid   = 1'b0;
    logic             sym_stb    = 1'b0;
    logic             o_tready   = 1'b1;
    logic             i_tready;
    logic [31:0]      o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic [15:0]      ovf_cnt;
    logic [15:0]      pkt_cnt;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    logic [32:0] sb[$];

    qpsk_sym_scheduler #(
        .SPP_W   (SPP_W),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .ce_clk     (ce_clk),
        .ce_rst_n   (ce_rst_n),
        .cfg_enable (cfg_enable),
        .cfg_mode   (cfg_mode),
        .cfg_spp    (cfg_spp),
        .i_tdata    (i_tdata),
        .i_tvalid   (i_tvalid),
        .i_tready   (i_tready),
        .sym_stb    (sym_stb),
        .o_tdata    (o_tdata),
        .o_tlast    (o_tlast),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .ovf_cnt    (ovf_cnt),
        .pkt_cnt    (pkt_cnt),
        .busy       (busy)
    );

    always #5 ce_clk = ~ce_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_word(input logic last, input logic [31:0] d);
        sb.push_back({last, d});
    endfunction

    // Each accepted output beat is checked against the oldest expectation.
    always @(negedge ce_clk) begin
        if (ce_rst_n && o_tvalid && o_tready) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL extra_beat observed=%0h expected=none", {o_tlast, o_tdata});
            end
            if (sb.size() != 0) chk("beat", {31'b0, o_tlast, o_tdata}, {31'b0, sb.pop_front()});
        end
    end

    task automatic step();
        @(posedge ce_clk);
        #1;
    endtask

    task automatic start(input logic [1:0] mode, input logic [SPP_W-1:0] spp);
        cfg_mode   = mode;
        cfg_spp    = spp;
        cfg_enable = 1'b1;
        step();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || busy || o_tvalid) && n < 500) begin
            step();
            n++;
        end
        checks++;
        assert (n < 500) else begin
            failures++;
            $error("FAIL %s_timeout observed=%0d expected=<500", tag, n);
            sb.delete();
        end
        step();
        step();
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] first;
        logic [15:0] pkt0;

        // Reset values
        #2;
        chk("rst_valid_last_busy", {o_tvalid, o_tlast, busy}, 3'b000);
        chk("rst_tdata", o_tdata, 32'h0);
        chk("rst_counters", {ovf_cnt, pkt_cnt}, 32'h0);
        chk("rst_i_tready", i_tready, 1'b1);
        #20 ce_rst_n = 1'b1;
        step();

        // Mode 1, spp 4: one strobed sample every 16 valid cycles
        start(2'd1, 12'd4);
        chk("t1_busy", busy, 1'b1);
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 16; c++) begin
                d        = $urandom;
                i_tvalid = 1'b1;
                i_tdata  = d;
                sym_stb  = (c == 15);
                if (c == 15) exp_word((k % 4) == 3, d);
                step();
            end
        end
        i_tvalid   = 1'b0;
        sym_stb    = 1'b0;
        cfg_enable = 1'b0;
        drain("t1");
        chk("t1_pkt_cnt", pkt_cnt, 16'd2);

        // Mode 2, spp 1: 16 symbols I = -1, Q = +1
        pkt0 = pkt_cnt;
        start(2'd2, 12'd1);
        for (int s = 0; s < 16; s++) begin
            i_tvalid = 1'b1;
            sym_stb  = 1'b0;
            i_tdata  = $urandom;
            step();
            sym_stb  = 1'b1;
            i_tdata  = 32'hFFFF_0001;
            step();
        end
        exp_word(1'b1, 32'hAAAA_AAAA);
        i_tvalid   = 1'b0;
        sym_stb    = 1'b0;
        cfg_enable = 1'b0;
        drain("t2");
        chk("t2_pkt_delta", pkt_cnt - pkt0, 16'd1);

        // Mode 0, spp 8, downstream stalled for 40 cycles of continuous input
        pkt0     = pkt_cnt;
        start(2'd0, 12'd8);
        o_tready = 1'b0;
        first    = '0;
        for (int i = 0; i < 40; i++) begin
            d        = $urandom;
            i_tvalid = 1'b1;
            i_tdata  = d;
            if (i == 0) first = d;
            if (i < 16) exp_word((i % 8) == 7, d);
            step();
        end
        i_tvalid   = 1'b0;
        cfg_enable = 1'b0;
        chk("t3_ovf_cnt", ovf_cnt, 16'd24);
        chk("t3_stall_head", {o_tvalid, o_tlast, o_tdata}, {2'b10, first});
        step();
        chk("t3_stall_hold", {o_tvalid, o_tlast, o_tdata}, {2'b10, first});
        chk("t3_busy_idle", busy, 1'b0);
        o_tready = 1'b1;
        drain("t3");
        chk("t3_pkt_delta", pkt_cnt - pkt0, 16'd2);
        chk("t3_ovf_kept", ovf_cnt, 16'd24);

        // Mode 1, spp 5: disable together with the 2nd symbol, expect zero padding
        pkt0 = pkt_cnt;
        start(2'd1, 12'd5);
        chk("t4_ovf_cleared", ovf_cnt, 16'd0);
        d        = $urandom;
        i_tvalid = 1'b1;
        sym_stb  = 1'b1;
        i_tdata  = d;
        exp_word(1'b0, d);
        step();
        d          = $urandom;
        i_tdata    = d;
        cfg_enable = 1'b0;
        exp_word(1'b0, d);
        step();
        i_tvalid = 1'b0;
        sym_stb  = 1'b0;
        chk("t4_busy_flush", busy, 1'b1);
        exp_word(1'b0, 32'h0);
        exp_word(1'b0, 32'h0);
        exp_word(1'b1, 32'h0);
        drain("t4");
        chk("t4_busy_fall", busy, 1'b0);
        chk("t4_pkt_delta", pkt_cnt - pkt0, 16'd1);

        // Mode 2, spp 3: partial packed word from 3 symbols then padding
        start(2'd2, 12'd3);
        i_tvalid = 1'b1;
        sym_stb  = 1'b1;
        i_tdata  = 32'h8000_8000;
        step();
        i_tdata  = 32'h0001_8000;
        step();
        i_tdata    = 32'h8000_0001;
        cfg_enable = 1'b0;
        step();
        i_tvalid = 1'b0;
        sym_stb  = 1'b0;
        exp_word(1'b0, 32'hD800_0000);
        exp_word(1'b0, 32'h0);
        exp_word(1'b1, 32'h0);
        drain("t5");

        // Reset asserted mid-packet with words waiting in the FIFO
        start(2'd0, 12'd8);
        o_tready = 1'b0;
        first    = '0;
        for (int i = 0; i < 3; i++) begin
            d        = $urandom | 32'h1;
            i_tvalid = 1'b1;
            i_tdata  = d;
            if (i == 0) first = d;
            step();
        end
        i_tvalid = 1'b0;
        step();
        chk("t6_pre_head", {o_tvalid, o_tdata}, {1'b1, first});
        #2 ce_rst_n = 1'b0;
        #1;
        chk("t6_rst_valid_last_busy", {o_tvalid, o_tlast, busy}, 3'b000);
        chk("t6_rst_tdata", o_tdata, 32'h0);
        chk("t6_rst_counters", {ovf_cnt, pkt_cnt}, 32'h0);
        cfg_enable = 1'b0;
        #2 ce_rst_n = 1'b1;
        o_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_tvalid = 1'b1;
            i_tdata  = $urandom;
            step();
            chk("t6_quiet", {o_tvalid, busy}, 2'b00);
        end
        i_tvalid = 1'b0;
        start(2'd0, 12'd2);
        d        = $urandom;
        i_tvalid = 1'b1;
        i_tdata  = d;
        exp_word(1'b0, d);
        step();
        d          = $urandom;
        i_tdata    = d;
        cfg_enable = 1'b0;
        exp_word(1'b1, d);
        step();
        i_tvalid = 1'b0;
        drain("t6");
        chk("t6_pkt_after_reset", pkt_cnt, 16'd1);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
